// File: rtl/uart_tx_unit_if.sv
// Byte-write / serial-output bundle between the memory-control stage and the UART transmitter.
interface uart_tx_unit_if;
  logic [7:0] uart;
  logic       uartWe;
  logic       txd;
  logic       fifoFull;
  logic       txBusy;
  logic [7:0] dropCount;

  modport master (
    output uart, uartWe,
    input  txd, fifoFull, txBusy, dropCount
  );

  modport slave (
    input  uart, uartWe,
    output txd, fifoFull, txBusy, dropCount
  );
endinterface

// File: rtl/uart_tx_unit.sv
// 8N1 UART transmitter fed by a byte FIFO. Writes that arrive while the FIFO
// is full are discarded and counted in a saturating drop counter.
module uart_tx_unit #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input logic           clk,
  input logic           rst,
  uart_tx_unit_if.slave bus
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic [7:0]    drop_q, drop_d;
  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;

  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  logic baud_last;

  // Status derived purely from the registered pointers.
  always_comb begin
    fifo_empty = (wptr_q == rptr_q);
    fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  end

  // FIFO pointer and drop-counter next state; a write while full is lost even if a pop frees a slot this cycle.
  always_comb begin
    push   = bus.uartWe && !fifo_full;
    wptr_d = push ? wptr_q + (AW+1)'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + (AW+1)'(1) : rptr_q;
    drop_d = drop_q;
    if (bus.uartWe && fifo_full && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  // Byte storage; no reset needed since the pointers define validity.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wptr_q[AW-1:0]] <= bus.uart;
    end
  end

  // Transmitter next state; txd_d anticipates the line level of the next state so txd stays a plain flop.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    txd_d     = txd_q;
    pop       = 1'b0;
    baud_last = (baud_q == BAUD_LAST);
    unique case (state_q)
      IDLE: begin
        txd_d  = 1'b1;
        baud_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rptr_q[AW-1:0]];
          state_d = START;
          txd_d   = 1'b0;
        end
      end
      START: begin
        if (baud_last) begin
          state_d   = DATA;
          baud_d    = '0;
          bit_idx_d = '0;
          txd_d     = shift_q[0];
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_d    = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            txd_d = shift_q[1];
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      STOP: begin
        txd_d = 1'b1;
        if (baud_last) begin
          state_d = IDLE;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
        txd_d   = 1'b1;
      end
    endcase
  end

  // All control state; reset aborts any frame and flushes the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wptr_q    <= '0;
      rptr_q    <= '0;
      drop_q    <= '0;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      drop_q    <= drop_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
    end
  end

  assign bus.txd       = txd_q;
  assign bus.fifoFull  = fifo_full;
  assign bus.txBusy    = (state_q != IDLE) || !fifo_empty;
  assign bus.dropCount = drop_q;

endmodule

// File: doc/uart_tx_unit.md
UART_TX_UNIT -- requirements
Module: uart_tx_unit

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868: clock cycles per serial bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16: number of byte entries in the transmit FIFO; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port uart, input, 8 bits: byte to transmit, driven by the memory-control stage.
REQ-006 SHALL have port uartWe, input, 1 bit: write strobe; when high, uart is pushed into the FIFO.
REQ-007 SHALL have port txd, output, 1 bit: serial line, 8N1 format, idle high.
REQ-008 SHALL have port fifoFull, output, 1 bit: high when the FIFO holds FIFO_DEPTH entries.
REQ-009 SHALL have port txBusy, output, 1 bit: high when a frame is in progress or the FIFO is non-empty.
REQ-010 SHALL have port dropCount, output, 8 bits: saturating count of writes discarded because the FIFO was full.

Function
REQ-011 SHALL implement the FIFO with read and write pointers of log2(FIFO_DEPTH)+1 bits and modulo-FIFO_DEPTH indexing; pointers SHALL wrap without loss.
REQ-012 SHALL push on a cycle where uartWe=1 and fifoFull=0; the pushed byte is readable by the transmitter from the next cycle.
REQ-013 SHALL discard the write on a cycle where uartWe=1 and fifoFull=1, even if a pop occurs in the same cycle, and SHALL increment dropCount, saturating at 255.
REQ-014 SHALL support a push and a pop in the same cycle when not full; the occupancy is then unchanged.
REQ-015 SHALL use a transmitter FSM with states IDLE, START, DATA and STOP; the state and all counters SHALL be registers.
REQ-016 In IDLE, txd=1; when the FIFO is non-empty, the unit SHALL pop the head into a shift register and enter START on the next cycle.
REQ-017 START SHALL drive txd=0 for exactly CLKS_PER_BIT cycles, then enter DATA with bitIdx=0.
REQ-018 DATA SHALL drive txd=shift[0] for CLKS_PER_BIT cycles per bit, sending the LSB first; it SHALL shift right and increment bitIdx after each bit, and after bit 7 SHALL enter STOP.
REQ-019 STOP SHALL drive txd=1 for exactly CLKS_PER_BIT cycles, then enter IDLE.
REQ-020 A single baud counter SHALL count 0..CLKS_PER_BIT-1 and reset to 0 on every state change.
REQ-021 Back-to-back frames SHALL be separated by exactly one IDLE cycle (txd=1).
REQ-022 Latency: for a uartWe pulse on cycle N with an empty FIFO and the FSM in IDLE, the pop SHALL occur on cycle N+1 and txd SHALL first be 0 on cycle N+2.
REQ-023 A frame SHALL last 10*CLKS_PER_BIT cycles from the first START cycle to the last STOP cycle.
REQ-024 txd SHALL be driven directly from a register, with no combinational path from the inputs.
REQ-025 fifoFull and txBusy SHALL be derived from registered state only.
REQ-026 The FIFO contents, uart and uartWe SHALL have no effect on the frame currently being transmitted.

Reset
REQ-027 While rst=1, the FSM SHALL be in IDLE, the pointers and baud counter at 0, bitIdx at 0, and dropCount at 0.
REQ-028 While rst=1, the outputs SHALL be txd=1, fifoFull=0, txBusy=0 and dropCount=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame and flush the FIFO; txd SHALL be 1 from the cycle after the rst edge.
REQ-030 A uartWe pulse in a cycle where rst=1 SHALL be ignored.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-031 Single byte: uart=0x55 with uartWe on cycle N -> txd low on cycles N+2..N+5, then bits 1,0,1,0,1,0,1,0 for 4 cycles each, stop bit high for 4 cycles, txBusy=0 afterwards.
REQ-032 Burst: writes of 0x01, 0x80, 0xFF on consecutive cycles -> three correctly formed frames in order, exactly one idle cycle between frames, no drops.
REQ-033 Overflow: six writes on consecutive cycles while the FSM is in IDLE -> one byte popped, four bytes buffered, fifoFull=1, the sixth write dropped, dropCount=1, and five frames transmitted.
REQ-034 Saturation: 300 writes while the FIFO is full -> dropCount=255 and no wrap to 0.
REQ-035 Reset mid-frame: rst asserted during DATA bit 3 -> txd=1 and txBusy=0 on the next cycle, no stale frame transmitted after rst is released.
REQ-036 Pointer wrap: 10 frames pushed and drained with push/pop coinciding -> the received byte sequence equals the sent sequence.
